adc_dcm_phase_ctrl: RTL and testbench

Sequencer for the variable-phase-shift port of one ADC capture DCM (the `dcm_psen`/`dcm_psincdec`/`dcm_psdone`/`dcm_rst` group on the ADC board interface). Software writes a signed target phase; the block walks the DCM one tap at a time, one outstanding shift at a time, and tracks the current phase. It also owns the DCM reset sequence, on software request or on loss of lock. One instance sits per ADC board, clocked by the DCM phase-shift clock.

---
 rtl/adc_dcm_phase_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_adc_dcm_phase_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dcm_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_dcm_phase_ctrl
// Purpose  : Walks the variable-phase-shift port of one ADC capture DCM toward
//            a clamped signed target, one tap at a time. Tracks the applied
//            phase and sequences the DCM reset on request or on lock loss.
// Revision : 1.0 - initial release
// ============================================================================
module adc_dcm_phase_ctrl #(
   parameter int PHASE_W     = 9,
   parameter int MAX_PHASE   = 255,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1023,
   parameter int RST_CYC     = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [PHASE_W-1:0] target_phase,
   input  logic               target_valid,
   output logic               target_ready,
   input  logic               rst_req,
   input  logic               err_clear,
   input  logic               dcm_locked,
   input  logic               dcm_psdone,
   output logic               dcm_psen,
   output logic               dcm_psincdec,
   output logic               dcm_rst,
   output logic [PHASE_W-1:0] cur_phase,
   output logic               busy,
   output logic               clamped,
   output logic               err_timeout,
   output logic               err_lock
);

   // One shared timer serves the settle, timeout and reset-pulse counts.
   localparam int TMAX_A = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int TMAX   = (TMAX_A > RST_CYC) ? TMAX_A : RST_CYC;
   localparam int TMR_W  = $clog2(TMAX + 1);

   localparam logic signed [PHASE_W-1:0] C_MAX = PHASE_W'(MAX_PHASE);
   localparam logic signed [PHASE_W-1:0] C_MIN = -C_MAX;
   localparam logic signed [PHASE_W-1:0] C_ONE = PHASE_W'(1);
   localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] C_TIMEOUT  = TMR_W'(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] C_SETTLE_L = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] C_RST_L    = TMR_W'(RST_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_STEP      = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_SETTLE    = 3'd3,
      S_DCM_RST   = 3'd4,
      S_WAIT_LOCK = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic signed [PHASE_W-1:0] tgt_q, tgt_d;
   logic signed [PHASE_W-1:0] cur_q, cur_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      rst_pend_q, rst_pend_d;
   logic                      psen_q, psen_d;
   logic                      incdec_q, incdec_d;
   logic                      dcm_rst_q, dcm_rst_d;
   logic                      busy_q, busy_d;
   logic                      clamped_q, clamped_d;
   logic                      err_to_q, err_to_d;
   logic                      err_lk_q, err_lk_d;

   logic signed [PHASE_W-1:0] tp_s;
   logic signed [PHASE_W-1:0] tp_clamped;
   logic                      tp_over;
   logic                      set_clamp, set_to, set_lock;

   // Handshake is decided from the current state and live request inputs.
   assign target_ready = (state_q == S_IDLE) & dcm_locked & ~rst_req;

   // Saturate the incoming request to the legal phase window.
   always_comb begin
      tp_s       = $signed(target_phase);
      tp_clamped = tp_s;
      tp_over    = 1'b0;
      if (tp_s > C_MAX) begin
         tp_clamped = C_MAX;
         tp_over    = 1'b1;
      end else if (tp_s < C_MIN) begin
         tp_clamped = C_MIN;
         tp_over    = 1'b1;
      end
   end

   // Next-state and next-value logic for the tap sequencer.
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      cur_d     = cur_q;
      timer_d   = timer_q;
      incdec_d  = incdec_q;
      set_clamp = 1'b0;
      set_to    = 1'b0;
      set_lock  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (target_valid && target_ready) begin
               tgt_d     = tp_clamped;
               set_clamp = tp_over;
            end
            if (rst_req || rst_pend_q) begin
               state_d = S_DCM_RST;
               timer_d = '0;
            end else if (dcm_locked && (tgt_q != cur_q)) begin
               state_d  = S_STEP;
               incdec_d = (tgt_q > cur_q);
            end
         end
         S_STEP: begin
            timer_d = '0;
            if (!dcm_locked) begin
               set_lock = 1'b1;
               state_d  = S_DCM_RST;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!dcm_locked) begin
               set_lock = 1'b1;
               state_d  = S_DCM_RST;
               timer_d  = '0;
            end else if (dcm_psdone) begin
               cur_d   = incdec_q ? (cur_q + C_ONE) : (cur_q - C_ONE);
               state_d = S_SETTLE;
               timer_d = '0;
            end else if (timer_q == C_TIMEOUT) begin
               // Abandon the walk where it stands rather than retrying.
               set_to  = 1'b1;
               tgt_d   = cur_q;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + C_TMR_ONE;
            end
         end
         S_SETTLE: begin
            if (!dcm_locked) begin
               set_lock = 1'b1;
               state_d  = S_DCM_RST;
               timer_d  = '0;
            end else if (timer_q == C_SETTLE_L) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + C_TMR_ONE;
            end
         end
         S_DCM_RST: begin
            if (timer_q == C_RST_L) begin
               // A freshly reset DCM sits at zero phase offset.
               cur_d   = '0;
               tgt_d   = '0;
               state_d = S_WAIT_LOCK;
            end else begin
               timer_d = timer_q + C_TMR_ONE;
            end
         end
         S_WAIT_LOCK: begin
            if (dcm_locked) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered outputs follow the next state; sticky flags let a set win.
   always_comb begin
      psen_d    = (state_d == S_STEP);
      dcm_rst_d = (state_d == S_DCM_RST);
      busy_d    = (state_d != S_IDLE);
      if ((state_d == S_DCM_RST) && (state_q != S_DCM_RST)) begin
         rst_pend_d = 1'b0;
      end else begin
         rst_pend_d = rst_pend_q | rst_req;
      end
      clamped_d = (clamped_q & ~err_clear) | set_clamp;
      err_to_d  = (err_to_q  & ~err_clear) | set_to;
      err_lk_d  = (err_lk_q  & ~err_clear) | set_lock;
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         tgt_q      <= '0;
         cur_q      <= '0;
         timer_q    <= '0;
         rst_pend_q <= 1'b0;
         psen_q     <= 1'b0;
         incdec_q   <= 1'b0;
         dcm_rst_q  <= 1'b0;
         busy_q     <= 1'b0;
         clamped_q  <= 1'b0;
         err_to_q   <= 1'b0;
         err_lk_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         cur_q      <= cur_d;
         timer_q    <= timer_d;
         rst_pend_q <= rst_pend_d;
         psen_q     <= psen_d;
         incdec_q   <= incdec_d;
         dcm_rst_q  <= dcm_rst_d;
         busy_q     <= busy_d;
         clamped_q  <= clamped_d;
         err_to_q   <= err_to_d;
         err_lk_q   <= err_lk_d;
      end
   end

   assign dcm_psen     = psen_q;
   assign dcm_psincdec = incdec_q;
   assign dcm_rst      = dcm_rst_q;
   assign cur_phase    = cur_q;
   assign busy         = busy_q;
   assign clamped      = clamped_q;
   assign err_timeout  = err_to_q;
   assign err_lock     = err_lk_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_dcm_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_dcm_phase_ctrl
// Purpose  : Self-checking bench for adc_dcm_phase_ctrl with a DCM PSDONE
//            responder, a pulse monitor and a tap-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_dcm_phase_ctrl;

   localparam int PW     = 10;
   localparam int MAXP   = 255;
   localparam int SETTLE = 16;
   localparam int TOUT   = 1023;
   localparam int RSTC   = 4;

   logic                 sys_clk = 1'b0;
   logic                 sys_rst_n = 1'b0;
   logic [PW-1:0]        target_phase = '0;
   logic                 target_valid = 1'b0;
   logic                 target_ready;
   logic                 rst_req = 1'b0;
   logic                 err_clear = 1'b0;
   logic                 dcm_locked = 1'b1;
   logic                 dcm_psdone;
   logic                 dcm_psen;
   logic                 dcm_psincdec;
   logic                 dcm_rst;
   logic [PW-1:0]        cur_phase;
   logic                 busy;
   logic                 clamped;
   logic                 err_timeout;
   logic                 err_lock;

   adc_dcm_phase_ctrl #(
      .PHASE_W(PW), .MAX_PHASE(MAXP), .SETTLE_CYC(SETTLE),
      .TIMEOUT_CYC(TOUT), .RST_CYC(RSTC)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .target_phase(target_phase), .target_valid(target_valid),
      .target_ready(target_ready), .rst_req(rst_req), .err_clear(err_clear),
      .dcm_locked(dcm_locked), .dcm_psdone(dcm_psdone), .dcm_psen(dcm_psen),
      .dcm_psincdec(dcm_psincdec), .dcm_rst(dcm_rst), .cur_phase(cur_phase),
      .busy(busy), .clamped(clamped), .err_timeout(err_timeout),
      .err_lock(err_lock)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int ref_cur = 0;

   // DCM model and monitor state. done_gap = cycles from the PSEN cycle to the
   // PSDONE cycle (0 = never answer).
   int cyc = 0;
   int done_gap = 6;
   int done_at = -1;
   int pulse_cnt = 0;
   int rst_hi_cnt = 0;
   int first_rst_cyc = -1;
   int overlap_cnt = 0;
   int pulse_cyc[$];
   bit pulse_dir[$];

   initial begin
      dcm_psdone = 1'b0;
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (dcm_psen) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            pulse_dir.push_back(dcm_psincdec);
            if (done_gap > 0) done_at = cyc + done_gap;
         end
         if (dcm_rst) begin
            rst_hi_cnt++;
            if (first_rst_cyc < 0) first_rst_cyc = cyc;
         end
         if (dcm_psen && dcm_rst) overlap_cnt++;
         dcm_psdone = (cyc == done_at);
      end
   end

   function automatic int clamp_ref(input int t);
      if (t > MAXP) return MAXP;
      if (t < -MAXP) return -MAXP;
      return t;
   endfunction

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic clear_mon();
      pulse_cnt = 0;
      rst_hi_cnt = 0;
      first_rst_cyc = -1;
      pulse_cyc.delete();
      pulse_dir.delete();
   endtask

   task automatic check_phase(input string name, input int exp);
      int e;
      e = exp;
      n_tests++;
      if (cur_phase !== e[PW-1:0]) begin
         n_fail++;
         $display("FAIL %s: cur_phase got %0d expected %0d", name, $signed(cur_phase), exp);
      end
   endtask

   task automatic wait_quiet(input int budget, input string name);
      int z;
      z = 0;
      for (int i = 0; i < budget && z < 2; i++) begin
         tick();
         z = busy ? 0 : z + 1;
      end
      if (z < 2) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: busy still %0b after %0d cycles, expected 0", name, busy, budget);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget, input string name);
      for (int i = 0; i < budget && pulse_cnt < n; i++) tick();
      if (pulse_cnt < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: saw %0d psen pulses, expected %0d", name, pulse_cnt, n);
      end
   endtask

   task automatic send_target(input int t, input string name);
      tick();
      target_phase = t[PW-1:0];
      target_valid = 1'b1;
      #1;
      n_tests++;
      if (target_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: target_ready got %0b expected 1", name, target_ready);
      end
      tick();
      target_valid = 1'b0;
   endtask

   task automatic clear_errors();
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   task automatic do_rst_req();
      tick();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      wait_quiet(50, "do_rst_req");
      ref_cur = 0;
   endtask

   task automatic test_reset();
      dcm_locked = 1'b1;
      repeat (3) tick();
      n_tests++;
      if ({dcm_psen, dcm_psincdec, dcm_rst, busy, clamped, err_timeout, err_lock} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {dcm_psen, dcm_psincdec, dcm_rst, busy, clamped, err_timeout, err_lock});
      end
      check_phase("reset_phase", 0);
      sys_rst_n = 1'b1;
      tick();
      n_tests++;
      if (target_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: target_ready got %0b expected 1", target_ready);
      end
      tick();
      n_tests++;
      if (dcm_psen !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: psen %0b busy %0b expected 0 0", dcm_psen, busy);
      end
   endtask

   // Walk to t with PSDONE answering gap cycles after each PSEN. One tap costs
   // STEP (1) + WAIT_DONE (gap) + SETTLE + one IDLE compare cycle.
   task automatic test_walk(input int t, input int gap, input string name);
      int exp_tgt, exp_n, exp_sp, bad_dir, bad_sp;
      bit exp_dir, exp_clamp;
      exp_tgt   = clamp_ref(t);
      exp_clamp = (exp_tgt != t);
      exp_n     = iabs(exp_tgt - ref_cur);
      exp_dir   = (exp_tgt > ref_cur);
      exp_sp    = gap + SETTLE + 2;
      done_gap  = gap;
      clear_mon();
      send_target(t, name);
      wait_quiet(exp_n * (exp_sp + 2) + 40, name);
      bad_dir = 0;
      bad_sp  = 0;
      foreach (pulse_dir[i]) if (pulse_dir[i] != exp_dir) bad_dir++;
      for (int i = 1; i < pulse_cyc.size(); i++)
         if (pulse_cyc[i] - pulse_cyc[i-1] != exp_sp) bad_sp++;
      n_tests++;
      if (pulse_cnt != exp_n) begin
         n_fail++;
         $display("FAIL %s_count: pulses got %0d expected %0d", name, pulse_cnt, exp_n);
      end
      n_tests++;
      if (bad_dir != 0) begin
         n_fail++;
         $display("FAIL %s_dir: %0d pulses had wrong psincdec, expected dir %0b", name, bad_dir, exp_dir);
      end
      n_tests++;
      if (bad_sp != 0) begin
         n_fail++;
         $display("FAIL %s_spacing: %0d gaps differ from required %0d (first gap %0d)",
                  name, bad_sp, exp_sp, (pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1);
      end
      check_phase(name, exp_tgt);
      n_tests++;
      if ({clamped, err_timeout, err_lock} !== {exp_clamp, 2'b00}) begin
         n_fail++;
         $display("FAIL %s_flags: got %b expected %b", name,
                  {clamped, err_timeout, err_lock}, {exp_clamp, 2'b00});
      end
      ref_cur = exp_tgt;
   endtask

   task automatic test_rst_collision();
      clear_mon();
      tick();
      target_phase = 10'sd5;
      target_valid = 1'b1;
      rst_req = 1'b1;
      #1;
      n_tests++;
      if (target_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_ready: target_ready got %0b expected 0", target_ready);
      end
      tick();
      target_valid = 1'b0;
      rst_req = 1'b0;
      n_tests++;
      if (dcm_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_rst_rise: dcm_rst got %0b expected 1", dcm_rst);
      end
      wait_quiet(50, "collide");
      repeat (20) tick();
      n_tests++;
      if (rst_hi_cnt != RSTC || pulse_cnt != 0) begin
         n_fail++;
         $display("FAIL collide_seq: rst cycles %0d psen %0d expected %0d 0", rst_hi_cnt, pulse_cnt, RSTC);
      end
      check_phase("collide_phase", 0);
      ref_cur = 0;
   endtask

   task automatic test_clamp();
      test_walk(-300, 1, "clamp_neg");
      clear_errors();
      n_tests++;
      if (clamped !== 1'b0) begin
         n_fail++;
         $display("FAIL clamp_clear: clamped got %0b expected 0", clamped);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         int off, gap;
         off = int'($urandom_range(0, 24)) - 12;
         gap = int'($urandom_range(1, 8));
         clear_errors();
         test_walk(ref_cur + off, gap, $sformatf("rand%0d", k));
      end
   endtask

   task automatic test_timeout();
      int p;
      do_rst_req();
      clear_errors();
      done_gap = 0;
      clear_mon();
      send_target(3, "tmo");
      wait_pulses(1, 10, "tmo_first");
      p = (pulse_cyc.size() > 0) ? pulse_cyc[0] : cyc;
      while (cyc < p + 1022) tick();
      n_tests++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_early: err_timeout %0b busy %0b expected 0 1", err_timeout, busy);
      end
      while (cyc < p + 1027) tick();
      n_tests++;
      if (err_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_flag: err_timeout got %0b expected 1", err_timeout);
      end
      repeat (40) tick();
      n_tests++;
      if (pulse_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_abort: pulses %0d busy %0b expected 1 0", pulse_cnt, busy);
      end
      check_phase("tmo_phase", 0);
      ref_cur = 0;
      done_gap = 6;
   endtask

   task automatic test_lock_loss();
      clear_errors();
      done_gap = 6;
      clear_mon();
      send_target(5, "lock");
      wait_pulses(3, 200, "lock_pulses");
      tick();
      check_phase("lock_before", 2);
      dcm_locked = 1'b0;
      tick();
      n_tests++;
      if (err_lock !== 1'b1 || dcm_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_detect: err_lock %0b dcm_rst %0b expected 1 1", err_lock, dcm_rst);
      end
      repeat (30) tick();
      n_tests++;
      if (rst_hi_cnt != RSTC || busy !== 1'b1 || pulse_cnt != 3) begin
         n_fail++;
         $display("FAIL lock_wait: rst cycles %0d busy %0b pulses %0d expected %0d 1 3",
                  rst_hi_cnt, busy, pulse_cnt, RSTC);
      end
      check_phase("lock_cleared", 0);
      dcm_locked = 1'b1;
      wait_quiet(10, "lock_relock");
      repeat (10) tick();
      n_tests++;
      if (pulse_cnt != 3 || err_lock !== 1'b1 || overlap_cnt != 0) begin
         n_fail++;
         $display("FAIL lock_after: pulses %0d err_lock %0b overlap %0d expected 3 1 0",
                  pulse_cnt, err_lock, overlap_cnt);
      end
      ref_cur = 0;
   endtask

   task automatic test_rst_in_settle();
      int p;
      clear_errors();
      done_gap = 3;
      clear_mon();
      send_target(2, "settle");
      for (int i = 0; i < 50 && cur_phase !== 10'd1; i++) tick();
      check_phase("settle_first_tap", 1);
      repeat (3) tick();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      p = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -100;
      wait_quiet(100, "settle_rst");
      repeat (20) tick();
      n_tests++;
      if (first_rst_cyc != p + 3 + SETTLE + 2) begin
         n_fail++;
         $display("FAIL settle_rst_start: dcm_rst rose at cycle %0d expected %0d",
                  first_rst_cyc, p + 3 + SETTLE + 2);
      end
      n_tests++;
      if (rst_hi_cnt != RSTC || pulse_cnt != 1) begin
         n_fail++;
         $display("FAIL settle_seq: rst cycles %0d pulses %0d expected %0d 1", rst_hi_cnt, pulse_cnt, RSTC);
      end
      check_phase("settle_phase", 0);
      ref_cur = 0;
      done_gap = 6;
   endtask

   task automatic test_async_reset();
      done_gap = 6;
      clear_mon();
      send_target(4, "arst");
      wait_pulses(2, 100, "arst_pulses");
      tick();
      #2;
      sys_rst_n = 1'b0;
      #1;
      n_tests++;
      if ({dcm_psen, dcm_psincdec, dcm_rst, busy, clamped, err_timeout, err_lock} !== 7'b0) begin
         n_fail++;
         $display("FAIL arst_outputs: got %b expected 0000000",
                  {dcm_psen, dcm_psincdec, dcm_rst, busy, clamped, err_timeout, err_lock});
      end
      check_phase("arst_phase", 0);
      done_at = -1;
      tick();
      sys_rst_n = 1'b1;
      clear_mon();
      repeat (10) tick();
      n_tests++;
      if (busy !== 1'b0 || pulse_cnt != 0) begin
         n_fail++;
         $display("FAIL arst_idle: busy %0b pulses %0d expected 0 0", busy, pulse_cnt);
      end
      ref_cur = 0;
   endtask

   initial begin
      test_reset();
      test_walk(3, 6, "walk_up");
      test_rst_collision();
      test_clamp();
      test_random();
      test_timeout();
      test_lock_loss();
      test_rst_in_settle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
